// File: rtl/vga_timing_if.sv
// Raster timing bundle between the timing controller and the pixel generator.
// The controller drives the raster outputs. The consumer side supplies the
// advance enable.
interface vga_timing_if;
  logic       en;
  logic [1:0] pixel_state;
  logic [9:0] pixel_counter;
  logic [9:0] line_counter;
  logic       active;
  logic       hsync;
  logic       vsync;
  logic       line_start;
  logic       frame_start;

  modport master (
    input  en,
    output pixel_state, pixel_counter, line_counter,
    output active, hsync, vsync, line_start, frame_start
  );

  modport slave (
    output en,
    input  pixel_state, pixel_counter, line_counter,
    input  active, hsync, vsync, line_start, frame_start
  );
endinterface

// File: rtl/vga_timing_controller.sv
// Raster timing source for the text-mode display path.
// Each pixel takes 4 clk phases, which serve as the fetch slots.
// Registered outputs are decoded from the next-state counters, so each flag
// lines up with the counter values it describes in the same cycle.
module vga_timing_controller #(
  parameter int   H_VISIBLE   = 640,
  parameter int   H_FRONT     = 16,
  parameter int   H_SYNC      = 96,
  parameter int   H_BACK      = 48,
  parameter int   V_VISIBLE   = 480,
  parameter int   V_FRONT     = 10,
  parameter int   V_SYNC      = 2,
  parameter int   V_BACK      = 33,
  parameter logic SYNC_ACTIVE = 1'b0
) (
  input logic          clk,
  input logic          rst,
  vga_timing_if.master bus
);
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_range_check
    $fatal(1, "vga_timing_controller: H_TOTAL/V_TOTAL exceed 10-bit counter range");
  end

  localparam logic [9:0]  L_H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0]  L_V_LAST = 10'(V_TOTAL - 1);
  // Compare in 11 bits so a sync window that ends exactly at 1024 still decodes.
  localparam logic [10:0] L_H_VIS  = 11'(H_VISIBLE);
  localparam logic [10:0] L_HS_BEG = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] L_HS_END = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] L_V_VIS  = 11'(V_VISIBLE);
  localparam logic [10:0] L_VS_BEG = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] L_VS_END = 11'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [1:0]  r_ps;
  logic [9:0]  r_pc;
  logic [9:0]  r_lc;
  logic        r_active;
  logic        r_hsync;
  logic        r_vsync;
  logic        r_line_start;
  logic        r_frame_start;

  logic [1:0]  w_ps_nxt;
  logic [9:0]  w_pc_nxt;
  logic [9:0]  w_lc_nxt;
  logic [10:0] w_pc_ext;
  logic [10:0] w_lc_ext;
  logic        w_active_nxt;
  logic        w_hsync_nxt;
  logic        w_vsync_nxt;
  logic        w_line_start_nxt;
  logic        w_frame_start_nxt;

  // Next raster position: the phase always advances, and the counters step on phase 3.
  always_comb begin
    w_ps_nxt = r_ps + 2'd1;
    w_pc_nxt = r_pc;
    w_lc_nxt = r_lc;
    if (r_ps == 2'd3) begin
      if (r_pc == L_H_LAST) begin
        w_pc_nxt = '0;
        w_lc_nxt = (r_lc == L_V_LAST) ? '0 : r_lc + 10'd1;
      end else begin
        w_pc_nxt = r_pc + 10'd1;
      end
    end
  end

  assign w_pc_ext          = {1'b0, w_pc_nxt};
  assign w_lc_ext          = {1'b0, w_lc_nxt};
  assign w_active_nxt      = (w_pc_ext < L_H_VIS) && (w_lc_ext < L_V_VIS);
  assign w_hsync_nxt       = ((w_pc_ext >= L_HS_BEG) && (w_pc_ext < L_HS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  assign w_vsync_nxt       = ((w_lc_ext >= L_VS_BEG) && (w_lc_ext < L_VS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  assign w_line_start_nxt  = (w_ps_nxt == 2'd0) && (w_pc_nxt == 10'd0);
  assign w_frame_start_nxt = w_line_start_nxt && (w_lc_nxt == 10'd0);

  // Raster state and decoded outputs. A hold keeps the state and suppresses the pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ps          <= '0;
      r_pc          <= '0;
      r_lc          <= '0;
      r_active      <= 1'b0;
      r_hsync       <= ~SYNC_ACTIVE;
      r_vsync       <= ~SYNC_ACTIVE;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else if (bus.en) begin
      r_ps          <= w_ps_nxt;
      r_pc          <= w_pc_nxt;
      r_lc          <= w_lc_nxt;
      r_active      <= w_active_nxt;
      r_hsync       <= w_hsync_nxt;
      r_vsync       <= w_vsync_nxt;
      r_line_start  <= w_line_start_nxt;
      r_frame_start <= w_frame_start_nxt;
    end else begin
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end
  end

  assign bus.pixel_state   = r_ps;
  assign bus.pixel_counter = r_pc;
  assign bus.line_counter  = r_lc;
  assign bus.active        = r_active;
  assign bus.hsync         = r_hsync;
  assign bus.vsync         = r_vsync;
  assign bus.line_start    = r_line_start;
  assign bus.frame_start   = r_frame_start;
endmodule

// File: tb/tb_vga_timing_controller.sv
// Testbench for vga_timing_controller, using a reduced raster so whole frames fit in a short run.
// A reference model pushes the expected outputs for every driven cycle. Each
// scenario task pops those entries and compares them against the DUT.
module tb_vga_timing_controller;
  localparam int HV = 8, HF = 2, HS = 3, HB = 2;
  localparam int VV = 6, VF = 1, VS = 2, VB = 1;
  localparam int HT = HV + HF + HS + HB;   // 15 pixels
  localparam int VT = VV + VF + VS + VB;   // 10 lines
  localparam int FRAME_CYC = 4 * HT * VT;  // 600
  localparam int LINE_CYC  = 4 * HT;       // 60
  localparam logic SA = 1'b0;

  typedef struct packed {
    logic [1:0] ps;
    logic [9:0] pc;
    logic [9:0] lc;
    logic       act;
    logic       hs;
    logic       vs;
    logic       ls;
    logic       fs;
  } smp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  vga_timing_if bus();

  vga_timing_controller #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_ACTIVE(SA)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  smp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  int   m_ps, m_pc, m_lc;
  logic m_act, m_hs, m_vs, m_ls, m_fs;

  localparam smp_t RST_VAL = '{ps: 2'd0, pc: 10'd0, lc: 10'd0, act: 1'b0,
                               hs: ~SA, vs: ~SA, ls: 1'b0, fs: 1'b0};

  function automatic smp_t obs();
    smp_t s;
    s.ps  = bus.pixel_state;
    s.pc  = bus.pixel_counter;
    s.lc  = bus.line_counter;
    s.act = bus.active;
    s.hs  = bus.hsync;
    s.vs  = bus.vsync;
    s.ls  = bus.line_start;
    s.fs  = bus.frame_start;
    return s;
  endfunction

  function automatic smp_t mexp();
    smp_t s;
    s.ps  = 2'(m_ps);
    s.pc  = 10'(m_pc);
    s.lc  = 10'(m_lc);
    s.act = m_act;
    s.hs  = m_hs;
    s.vs  = m_vs;
    s.ls  = m_ls;
    s.fs  = m_fs;
    return s;
  endfunction

  task automatic model_reset();
    m_ps = 0; m_pc = 0; m_lc = 0;
    m_act = 1'b0; m_hs = ~SA; m_vs = ~SA; m_ls = 1'b0; m_fs = 1'b0;
  endtask

  // Drive one cycle from a negedge: predict, push, then move to the next negedge.
  task automatic cyc(input logic e);
    bus.en = e;
    if (e) begin
      if (m_ps == 3) begin
        if (m_pc == HT - 1) begin
          m_pc = 0;
          m_lc = (m_lc == VT - 1) ? 0 : m_lc + 1;
        end else begin
          m_pc = m_pc + 1;
        end
      end
      m_ps  = (m_ps + 1) % 4;
      m_act = (m_pc < HV) && (m_lc < VV);
      m_hs  = (m_pc >= HV + HF && m_pc < HV + HF + HS) ? SA : ~SA;
      m_vs  = (m_lc >= VV + VF && m_lc < VV + VF + VS) ? SA : ~SA;
      m_ls  = (m_ps == 0) && (m_pc == 0);
      m_fs  = m_ls && (m_lc == 0);
    end else begin
      m_ls = 1'b0;
      m_fs = 1'b0;
    end
    sb.push_back(mexp());
    @(negedge clk);
  endtask

  task automatic test_reset();
    smp_t e, o;
    rst = 1'b0;
    o = obs();
    n_checks++;
    if (o !== RST_VAL) $display("FAIL reset_initial: got %h want %h", o, RST_VAL);
    else n_pass++;
    for (int i = 0; i < 2 * LINE_CYC + 13; i++) begin
      cyc(1'b1);
      e = sb.pop_front(); o = obs();
      n_checks++;
      if (o !== e) $display("FAIL reset_prerun: got %h want %h", o, e);
      else n_pass++;
    end
    rst = 1'b1;
    #1;
    o = obs();
    n_checks++;
    if (o !== RST_VAL) $display("FAIL reset_async: got %h want %h", o, RST_VAL);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      o = obs();
      n_checks++;
      if (o !== RST_VAL) $display("FAIL reset_hold: got %h want %h", o, RST_VAL);
      else n_pass++;
    end
    model_reset();
    rst = 1'b0;
    o = obs();
    n_checks++;
    if (o !== RST_VAL) $display("FAIL reset_release: got %h want %h", o, RST_VAL);
    else n_pass++;
  endtask

  task automatic test_startup();
    smp_t e, o;
    int want_ps[4] = '{1, 2, 3, 0};
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1);
      e = sb.pop_front(); o = obs();
      n_checks++;
      if (o !== e) $display("FAIL startup_sb: got %h want %h", o, e);
      else n_pass++;
      n_checks++;
      if (o.ps !== 2'(want_ps[i]) || o.pc !== ((i == 3) ? 10'd1 : 10'd0) || o.act !== 1'b1)
        $display("FAIL startup_seq: step %0d got ps=%0d pc=%0d act=%b want ps=%0d", i, o.ps, o.pc, o.act, want_ps[i]);
      else n_pass++;
    end
  endtask

  task automatic test_hblank();
    smp_t e, o, prev;
    int lo_cnt = 0, lo_first = -1, hi_after = -1, act_fall_seen = 0;
    prev = obs();
    for (int i = 0; i < LINE_CYC; i++) begin
      cyc(1'b1);
      e = sb.pop_front(); o = obs();
      n_checks++;
      if (o !== e) $display("FAIL hblank_sb: got %h want %h", o, e);
      else n_pass++;
      if (o.pc == 10'(HV) && prev.pc == 10'(HV - 1)) begin
        act_fall_seen = 1;
        n_checks++;
        if (o.act !== 1'b0 || prev.act !== 1'b1)
          $display("FAIL active_fall: got act=%b prev_act=%b want 0 and 1", o.act, prev.act);
        else n_pass++;
      end
      if (o.hs === SA) begin
        lo_cnt++;
        if (lo_first < 0) lo_first = int'(o.pc);
      end else if (lo_first >= 0 && hi_after < 0) begin
        hi_after = int'(o.pc);
      end
      prev = o;
    end
    n_checks++;
    if (act_fall_seen == 0) $display("FAIL active_fall_seen: got 0 want 1");
    else n_pass++;
    n_checks++;
    if (lo_cnt != 4 * HS) $display("FAIL hsync_width: got %0d want %0d", lo_cnt, 4 * HS);
    else n_pass++;
    n_checks++;
    if (lo_first != HV + HF || hi_after != HV + HF + HS)
      $display("FAIL hsync_edges: got %0d/%0d want %0d/%0d", lo_first, hi_after, HV + HF, HV + HF + HS);
    else n_pass++;
  endtask

  task automatic test_frame_wrap();
    smp_t e, o;
    int found = 0, vs_min = 1 << 20, vs_max = -1;
    for (int i = 0; i < 2 * FRAME_CYC && found == 0; i++) begin
      cyc(1'b1);
      e = sb.pop_front(); o = obs();
      n_checks++;
      if (o !== e) $display("FAIL wrap_sb: got %h want %h", o, e);
      else n_pass++;
      if (o.vs === SA) begin
        if (int'(o.lc) < vs_min) vs_min = int'(o.lc);
        if (int'(o.lc) > vs_max) vs_max = int'(o.lc);
      end
      if (o.ps == 2'd3 && o.pc == 10'(HT - 1) && o.lc == 10'(VT - 1)) found = 1;
    end
    n_checks++;
    if (found == 0) $display("FAIL wrap_timeout: got no last pixel want one within %0d cycles", 2 * FRAME_CYC);
    else n_pass++;
    cyc(1'b1);
    e = sb.pop_front(); o = obs();
    n_checks++;
    if (o.ps !== 2'd0 || o.pc !== 10'd0 || o.lc !== 10'd0 || o.ls !== 1'b1 || o.fs !== 1'b1)
      $display("FAIL wrap_start: got %h want ps/pc/lc 0 ls=1 fs=1 (model %h)", o, e);
    else n_pass++;
    cyc(1'b1);
    e = sb.pop_front(); o = obs();
    n_checks++;
    if (o.ls !== 1'b0 || o.fs !== 1'b0 || o !== e)
      $display("FAIL wrap_pulse_end: got %h want %h", o, e);
    else n_pass++;
    n_checks++;
    if (vs_min != VV + VF || vs_max != VV + VF + VS - 1)
      $display("FAIL vsync_lines: got %0d..%0d want %0d..%0d", vs_min, vs_max, VV + VF, VV + VF + VS - 1);
    else n_pass++;
  endtask

  task automatic test_en_hold();
    smp_t e, o, frozen;
    int found = 0;
    for (int i = 0; i < 2 * FRAME_CYC && found == 0; i++) begin
      cyc(1'b1);
      e = sb.pop_front(); o = obs();
      n_checks++;
      if (o !== e) $display("FAIL hold_seek_sb: got %h want %h", o, e);
      else n_pass++;
      if (o.ps == 2'd2 && o.pc == 10'd5) found = 1;
    end
    n_checks++;
    if (found == 0) $display("FAIL hold_timeout: got no ps=2 pc=5 want one");
    else n_pass++;
    frozen = mexp();
    frozen.ls = 1'b0; frozen.fs = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0);
      e = sb.pop_front(); o = obs();
      n_checks++;
      if (o !== e || o !== frozen) $display("FAIL hold_frozen: got %h want %h", o, frozen);
      else n_pass++;
    end
    cyc(1'b1);
    e = sb.pop_front(); o = obs();
    n_checks++;
    if (o !== e || o.ps !== 2'd3 || o.pc !== 10'd5)
      $display("FAIL hold_resume: got ps=%0d pc=%0d want ps=3 pc=5", o.ps, o.pc);
    else n_pass++;
    cyc(1'b1);
    e = sb.pop_front(); o = obs();
    n_checks++;
    if (o !== e || o.ps !== 2'd0 || o.pc !== 10'd6)
      $display("FAIL hold_resume2: got ps=%0d pc=%0d want ps=0 pc=6", o.ps, o.pc);
    else n_pass++;
    // Freeze on the cycle a line_start pulse is showing: it must not stretch.
    found = 0;
    for (int i = 0; i < 2 * LINE_CYC && found == 0; i++) begin
      cyc(1'b1);
      e = sb.pop_front(); o = obs();
      n_checks++;
      if (o !== e) $display("FAIL hold_seek2_sb: got %h want %h", o, e);
      else n_pass++;
      if (o.ls === 1'b1) found = 1;
    end
    n_checks++;
    if (found == 0) $display("FAIL hold_pulse_timeout: got no line_start want one");
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0);
      e = sb.pop_front(); o = obs();
      n_checks++;
      if (o !== e || o.ls !== 1'b0 || o.pc !== 10'd0 || o.ps !== 2'd0)
        $display("FAIL hold_no_pulse: got %h want %h", o, e);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    smp_t e, o;
    int last_fs = -1, last_ls = -1, n_fs = 0, n_ls = 0;
    for (int i = 0; i < 2 * FRAME_CYC + 2 * LINE_CYC; i++) begin
      cyc(1'b1);
      e = sb.pop_front(); o = obs();
      n_checks++;
      if (o !== e) $display("FAIL b2b_sb: got %h want %h", o, e);
      else n_pass++;
      if (o.fs === 1'b1) begin
        if (last_fs >= 0) begin
          n_checks++;
          if (i - last_fs != FRAME_CYC) $display("FAIL frame_spacing: got %0d want %0d", i - last_fs, FRAME_CYC);
          else n_pass++;
        end
        last_fs = i; n_fs++;
      end
      if (o.ls === 1'b1) begin
        if (last_ls >= 0) begin
          n_checks++;
          if (i - last_ls != LINE_CYC) $display("FAIL line_spacing: got %0d want %0d", i - last_ls, LINE_CYC);
          else n_pass++;
        end
        last_ls = i; n_ls++;
      end
    end
    n_checks++;
    if (n_fs < 2 || n_ls < 2 * VT) $display("FAIL pulse_count: got fs=%0d ls=%0d want >=2 and >=%0d", n_fs, n_ls, 2 * VT);
    else n_pass++;
  endtask

  initial begin
    bus.en = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    test_reset();
    test_startup();
    test_hblank();
    test_frame_wrap();
    test_en_hold();
    test_back_to_back();
    n_checks++;
    if (sb.size() != 0) $display("FAIL scoreboard_drain: got %0d entries want 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/vga_timing_controller.md
Name: vga_timing_controller

Overview:
- Raster timing source for the text-mode display path; sits directly upstream of the pixel generator.
- Generates the fetch phase (pixel_state), the horizontal/vertical counters, the active-video flag and the hsync/vsync pins.
- Default timing is 640x480 @ ~60 Hz, from a 100 MHz system clock using 4 clk cycles per pixel (25 MHz pixel rate).
- The 4 phases give the pixel generator its char-fetch / glyph-fetch / glyph-data / spare slots.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_ACTIVE, 0, asserted level of hsync/vsync (0 = active-low)

Ports:
- clk  input  1  system clock, 100 MHz
- rst  input  1  asynchronous, active-high reset
- en  input  1  advance enable; when low the block holds all state
- pixel_state  output  2  fetch phase 0..3 within the current pixel
- pixel_counter  output  10  horizontal position, 0..H_TOTAL-1
- line_counter  output  10  vertical position, 0..V_TOTAL-1
- active  output  1  high while in the visible region
- hsync  output  1  horizontal sync pin
- vsync  output  1  vertical sync pin
- line_start  output  1  one-clk pulse at phase 0 of pixel 0 of every line
- frame_start  output  1  one-clk pulse at phase 0 of pixel 0 of line 0

Behaviour:
- H_TOTAL = sum of the four H_* parameters (800); V_TOTAL = sum of the four V_* parameters (525). Both must be <= 1024; this is checked at elaboration and fails on violation.
- Reset values (rst high, applied asynchronously):
  - pixel_state = 0, pixel_counter = 0, line_counter = 0
  - active = 0, line_start = 0, frame_start = 0
  - hsync = vsync = ~SYNC_ACTIVE
- All outputs are registered. active, hsync, vsync, line_start and frame_start are computed from the next-state counters/phase, so they are cycle-aligned with the counter values they describe.
- When en is high, on each clk edge:
  - pixel_state increments modulo 4.
  - The counters change only on the edge where pixel_state == 3.
  - pixel_counter increments; when pixel_counter == H_TOTAL-1 it wraps to 0 and line_counter increments.
  - line_counter wraps to 0 when it equals V_TOTAL-1 at the same H wrap.
- When en is low, every register holds its value. line_start and frame_start are forced to 0 while held, so a pulse never lasts more than one cycle.
- active = (pixel_counter < H_VISIBLE) && (line_counter < V_VISIBLE).
- hsync = SYNC_ACTIVE when H_VISIBLE+H_FRONT <= pixel_counter < H_VISIBLE+H_FRONT+H_SYNC (656..751); otherwise inverted.
- vsync = SYNC_ACTIVE when V_VISIBLE+V_FRONT <= line_counter < V_VISIBLE+V_FRONT+V_SYNC (490..491); otherwise inverted. vsync is evaluated on line_counter only, so it changes coincident with the H wrap.
- line_start = 1 exactly when the next state is (pixel_state=0, pixel_counter=0).
- frame_start additionally requires line_counter = 0.
- First cycle after rst deasserts: counters are 0,0 and pixel_state is 0, but active, line_start and frame_start are still 0; they follow normal alignment from the next edge on. The first frame_start therefore appears one full frame after reset. This is intended: the first partial phase after reset is not a fetch slot.
- Reset mid-frame: all state returns to reset values immediately; no completion of the line or frame.
- Frame period = 4 * 800 * 525 = 1,680,000 clk cycles.

Test Plan:
- Assert rst for 5 cycles mid-frame -> during and immediately after: counters 0/0, pixel_state 0, active 0, hsync = vsync = 1, line_start = frame_start = 0.
- Release rst, en = 1, run 4 cycles -> pixel_state sequence 1,2,3,0; pixel_counter 0->1 exactly on the 4th edge; active = 1 from the 2nd cycle.
- Run to pixel_counter = 639 -> 640 -> active falls in the same cycle pixel_counter reads 640; hsync goes low at 656 and high again at 752; width = 96*4 = 384 clk cycles.
- Run through pixel_counter 799, phase 3, line 524 -> next edge gives counters 0/0 with pixel_state 0; frame_start and line_start both pulse for 1 cycle; vsync was low only for lines 490-491.
- Toggle en low for 10 cycles at pixel_state = 2, pixel_counter = 100 -> all outputs frozen, no pulses; resume continues from phase 3 with no skipped or duplicated count.
- Free-run 2 full frames -> frame_start spacing is exactly 1,680,000 cycles; line_start spacing is exactly 3,200 cycles.
